// File: rtl/spi_slave_mode.sv
// SPI slave: shifts DATA_WIDTH-bit words in on MOSI and out on MISO, all four SPI modes, either bit order.
// Latency: bus pins cross a 2-FF synchroniser; data_rdy_out / tx_load_out pulse one clk after the detecting edge.
// Backpressure: none. The master owns the bus; tx_data_in must be valid when tx_load_out would capture it.
//
// Ports:
//   clk_in, spi_rst_n           system clock, async active-low reset
//   spi_sclk_in/mosi_in/cs_n_in raw SPI bus inputs (asynchronous to clk_in)
//   spi_miso_out                registered slave data out, 0 outside a frame
//   tx_data_in / tx_load_out    next word to send / pulse when it was captured
//   data_out / data_rdy_out     last complete received word / pulse when updated
//   frame_active_out            synchronised CS asserted
//   frame_err_out               pulse when CS rose in the middle of a word
//   word_cnt_out                words completed in this frame, saturating
module spi_slave_mode #(
   parameter int DATA_WIDTH = 8,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0,
   parameter int MSB_FIRST  = 1
) (
   input  logic                  clk_in,
   input  logic                  spi_rst_n,
   input  logic                  spi_sclk_in,
   input  logic                  spi_mosi_in,
   input  logic                  spi_cs_n_in,
   output logic                  spi_miso_out,
   input  logic [DATA_WIDTH-1:0] tx_data_in,
   output logic                  tx_load_out,
   output logic                  data_rdy_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_active_out,
   output logic                  frame_err_out,
   output logic [15:0]           word_cnt_out
);

   localparam int            BW          = $clog2(DATA_WIDTH);
   localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_WIDTH - 1);
   localparam bit            SAMPLE_RISE = (CPOL == CPHA);

   // UNARMED: after reset, until CS has been seen deasserted through a valid
   // synchroniser. This keeps a reset released mid-frame from looking like a
   // fresh CS assertion.
   typedef enum logic [1:0] {ST_UNARMED, ST_IDLE, ST_ACTIVE} state_t;

   state_t                r_state;
   logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic                  r_mosi_s1, r_mosi_s2;
   logic                  r_cs_s1, r_cs_s2, r_cs_d;
   logic [1:0]            r_sync_vld;
   logic [BW-1:0]         r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_rx_shift;
   logic [DATA_WIDTH-1:0] r_tx_shift;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_data_rdy, r_tx_load, r_frame_err, r_frame_active, r_miso;
   logic [15:0]           r_word_cnt;

   logic                  w_sclk_rise, w_sclk_fall;
   logic                  w_sample_edge, w_shift_edge;
   logic                  w_cs_fall;
   logic [DATA_WIDTH-1:0] w_rx_next;
   logic                  w_tx_head, w_tx_head_in;
   logic [DATA_WIDTH-1:0] w_tx_adv, w_tx_in_adv;

   assign w_sclk_rise   = r_sclk_s2 & ~r_sclk_d;
   assign w_sclk_fall   = ~r_sclk_s2 & r_sclk_d;
   assign w_sample_edge = SAMPLE_RISE ? w_sclk_rise : w_sclk_fall;
   assign w_shift_edge  = SAMPLE_RISE ? w_sclk_fall : w_sclk_rise;
   assign w_cs_fall     = r_cs_d & ~r_cs_s2;

   assign w_rx_next    = (MSB_FIRST != 0) ? {r_rx_shift[DATA_WIDTH-2:0], r_mosi_s2}
                                          : {r_mosi_s2, r_rx_shift[DATA_WIDTH-1:1]};
   // The head of r_tx_shift is always the next bit to put on MISO.
   assign w_tx_head    = (MSB_FIRST != 0) ? r_tx_shift[DATA_WIDTH-1] : r_tx_shift[0];
   assign w_tx_adv     = (MSB_FIRST != 0) ? {r_tx_shift[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
   assign w_tx_head_in = (MSB_FIRST != 0) ? tx_data_in[DATA_WIDTH-1] : tx_data_in[0];
   assign w_tx_in_adv  = (MSB_FIRST != 0) ? {tx_data_in[DATA_WIDTH-2:0], 1'b0}
                                          : {1'b0, tx_data_in[DATA_WIDTH-1:1]};

   always_ff @(posedge clk_in or negedge spi_rst_n) begin
      if (!spi_rst_n) begin
         r_state        <= ST_UNARMED;
         r_sclk_s1      <= 1'b0;
         r_sclk_s2      <= 1'b0;
         r_sclk_d       <= 1'b0;
         r_mosi_s1      <= 1'b0;
         r_mosi_s2      <= 1'b0;
         r_cs_s1        <= 1'b1;
         r_cs_s2        <= 1'b1;
         r_cs_d         <= 1'b1;
         r_sync_vld     <= 2'b00;
         r_bit_cnt      <= '0;
         r_rx_shift     <= '0;
         r_tx_shift     <= '0;
         r_data         <= '0;
         r_data_rdy     <= 1'b0;
         r_tx_load      <= 1'b0;
         r_frame_err    <= 1'b0;
         r_frame_active <= 1'b0;
         r_miso         <= 1'b0;
         r_word_cnt     <= '0;
      end else begin
         r_sclk_s1  <= spi_sclk_in;
         r_sclk_s2  <= r_sclk_s1;
         r_sclk_d   <= r_sclk_s2;
         r_mosi_s1  <= spi_mosi_in;
         r_mosi_s2  <= r_mosi_s1;
         r_cs_s1    <= spi_cs_n_in;
         r_cs_s2    <= r_cs_s1;
         r_cs_d     <= r_cs_s2;
         r_sync_vld <= {r_sync_vld[0], 1'b1};

         r_data_rdy  <= 1'b0;
         r_tx_load   <= 1'b0;
         r_frame_err <= 1'b0;

         case (r_state)
            ST_UNARMED: begin
               r_miso    <= 1'b0;
               r_bit_cnt <= '0;
               // r_cs_s2 only reflects the pin once both stages have refilled.
               if (r_sync_vld[1] && r_cs_s2)
                  r_state <= ST_IDLE;
            end

            ST_IDLE: begin
               r_miso    <= 1'b0;
               r_bit_cnt <= '0;
               if (w_cs_fall) begin
                  r_state        <= ST_ACTIVE;
                  r_frame_active <= 1'b1;
                  r_word_cnt     <= '0;
                  r_rx_shift     <= '0;
                  r_tx_load      <= 1'b1;
                  if (CPHA == 0) begin
                     // First bit must be on MISO before the first (sampling) edge.
                     r_miso     <= w_tx_head_in;
                     r_tx_shift <= w_tx_in_adv;
                  end else begin
                     r_tx_shift <= tx_data_in;
                  end
               end
            end

            ST_ACTIVE: begin
               // CS deassertion wins over any SCLK edge seen in the same cycle.
               if (r_cs_s2) begin
                  r_state        <= ST_IDLE;
                  r_frame_active <= 1'b0;
                  r_miso         <= 1'b0;
                  r_bit_cnt      <= '0;
                  r_rx_shift     <= '0;
                  if (r_bit_cnt != '0)
                     r_frame_err <= 1'b1;
               end else begin
                  if (w_shift_edge) begin
                     r_miso     <= w_tx_head;
                     r_tx_shift <= w_tx_adv;
                  end
                  if (w_sample_edge) begin
                     r_rx_shift <= w_rx_next;
                     if (r_bit_cnt == LAST_BIT) begin
                        r_bit_cnt  <= '0;
                        r_data     <= w_rx_next;
                        r_data_rdy <= 1'b1;
                        // Reloaded unshifted: the next shift edge presents its first bit.
                        r_tx_shift <= tx_data_in;
                        r_tx_load  <= 1'b1;
                        if (r_word_cnt != 16'hFFFF)
                           r_word_cnt <= r_word_cnt + 16'd1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end
               end
            end

            default: r_state <= ST_UNARMED;
         endcase
      end
   end

   assign spi_miso_out     = r_miso;
   assign tx_load_out      = r_tx_load;
   assign data_rdy_out     = r_data_rdy;
   assign data_out         = r_data;
   assign frame_active_out = r_frame_active;
   assign frame_err_out    = r_frame_err;
   assign word_cnt_out     = r_word_cnt;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: four 8-bit MSB-first instances (modes 0..3) and one
// 16-bit LSB-first mode-0 instance. A master task drives one instance at a time,
// pushing expected received words and expected MISO words into queues; monitors
// pop and compare whenever data_rdy_out pulses or a full MISO word is sampled.
module tb_spi_slave_mode;

   localparam int HP = 8;   // SCLK half period in clk_in cycles
   localparam logic [4:0] CFG_CPOL = 5'b01100;
   localparam logic [4:0] CFG_CPHA = 5'b01010;
   localparam logic [4:0] CFG_MSB  = 5'b01111;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;
   logic [4:0]  sclk   = 5'b01100;
   logic [4:0]  mosi   = 5'b00000;
   logic [4:0]  cs_n   = 5'b11111;
   logic [7:0]  txd8 [4];
   logic [15:0] txd16;
   logic [4:0]  miso, tx_load, rdy, err, active;
   logic [7:0]  dout8 [4];
   logic [15:0] dout16;
   logic [15:0] wcnt [5];

   logic [15:0] exp_rx[$];
   logic [15:0] exp_tx[$];
   logic [15:0] mst_tx [5];
   logic [15:0] slv_tx [5];

   int n_cmp = 0;
   int n_bad = 0;
   int rdy_cnt [5];
   int load_cnt [5];
   int err_cnt [5];

   always #5 clk_in = ~clk_in;

   for (genvar g = 0; g < 4; g++) begin : g_m8
      spi_slave_mode #(.DATA_WIDTH(8), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(1)) u_dut (
         .clk_in(clk_in), .spi_rst_n(rst_n),
         .spi_sclk_in(sclk[g]), .spi_mosi_in(mosi[g]), .spi_cs_n_in(cs_n[g]),
         .spi_miso_out(miso[g]), .tx_data_in(txd8[g]), .tx_load_out(tx_load[g]),
         .data_rdy_out(rdy[g]), .data_out(dout8[g]), .frame_active_out(active[g]),
         .frame_err_out(err[g]), .word_cnt_out(wcnt[g]));
   end

   spi_slave_mode #(.DATA_WIDTH(16), .CPOL(0), .CPHA(0), .MSB_FIRST(0)) u_dut16 (
      .clk_in(clk_in), .spi_rst_n(rst_n),
      .spi_sclk_in(sclk[4]), .spi_mosi_in(mosi[4]), .spi_cs_n_in(cs_n[4]),
      .spi_miso_out(miso[4]), .tx_data_in(txd16), .tx_load_out(tx_load[4]),
      .data_rdy_out(rdy[4]), .data_out(dout16), .frame_active_out(active[4]),
      .frame_err_out(err[4]), .word_cnt_out(wcnt[4]));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic set_tx(input int idx, input logic [15:0] v);
      if (idx == 4) txd16 = v;
      else          txd8[idx] = v[7:0];
   endtask

   // One SCLK period; MOSI changes on the shift edge (or before the first edge for CPHA=0).
   task automatic do_bit(input int idx, input logic b);
      if (!CFG_CPHA[idx]) begin
         mosi[idx] = b;
         wait_clk(HP);
         sclk[idx] = ~CFG_CPOL[idx];
         wait_clk(HP);
         sclk[idx] = CFG_CPOL[idx];
      end else begin
         sclk[idx] = ~CFG_CPOL[idx];
         mosi[idx] = b;
         wait_clk(HP);
         sclk[idx] = CFG_CPOL[idx];
         wait_clk(HP);
      end
   endtask

   // nw complete words from mst_tx[], slave feeding slv_tx[], then 'extra' bits of a partial word.
   task automatic frame(input int idx, input int nw, input int extra);
      int w, wd, b;
      logic [15:0] v;
      w = (idx == 4) ? 16 : 8;
      for (int k = 0; k < nw; k++) begin
         exp_rx.push_back(mst_tx[k]);
         exp_tx.push_back(slv_tx[k]);
      end
      set_tx(idx, slv_tx[0]);
      cs_n[idx] = 1'b0;
      wait_clk(HP);
      check("frame_active", {31'd0, active[idx]}, 32'd1);
      for (int k = 0; k < nw * w + extra; k++) begin
         wd = k / w;
         b  = k % w;
         v  = mst_tx[wd];
         do_bit(idx, CFG_MSB[idx] ? v[w-1-b] : v[b]);
         if (b == 0) set_tx(idx, slv_tx[wd+1]);
      end
      wait_clk(HP);
      cs_n[idx] = 1'b1;
      wait_clk(12);
   endtask

   // Output monitors: received-word scoreboard, pulse counters, and a MISO
   // receiver that plays the master's input side.
   logic [4:0]  mon_ps = 5'b01100;
   int          mon_cnt [5];
   logic [15:0] mon_acc [5];

   always @(negedge clk_in) begin
      for (int i = 0; i < 5; i++) begin
         logic [15:0] dv, ev;
         int w;
         w  = (i == 4) ? 16 : 8;
         dv = (i == 4) ? dout16 : {8'h00, dout8[i]};
         if (rdy[i]) begin
            rdy_cnt[i]++;
            if (exp_rx.size() == 0) begin
               check("rx_unexpected", {16'd0, dv}, 32'hFFFF_FFFF);
            end else begin
               ev = exp_rx.pop_front();
               check("rx_word", {16'd0, dv}, {16'd0, ev});
            end
         end
         if (tx_load[i]) load_cnt[i]++;
         if (err[i])     err_cnt[i]++;

         if (!rst_n || cs_n[i]) begin
            mon_cnt[i] = 0;
            mon_acc[i] = '0;
         end else if (sclk[i] != mon_ps[i] && sclk[i] == (CFG_CPOL[i] == CFG_CPHA[i])) begin
            if (CFG_MSB[i]) mon_acc[i] = {mon_acc[i][14:0], miso[i]};
            else            mon_acc[i] = mon_acc[i] | (16'(miso[i]) << mon_cnt[i]);
            mon_cnt[i]++;
            if (mon_cnt[i] == w) begin
               if (exp_tx.size() == 0) begin
                  check("miso_unexpected", {16'd0, mon_acc[i]}, 32'hFFFF_FFFF);
               end else begin
                  ev = exp_tx.pop_front();
                  check("miso_word", {16'd0, mon_acc[i]}, {16'd0, ev});
               end
               mon_cnt[i] = 0;
               mon_acc[i] = '0;
            end
         end
         mon_ps[i] = sclk[i];
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int r0, l0, e0;
      for (int i = 0; i < 4; i++) txd8[i] = 8'h00;
      txd16 = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         rdy_cnt[i] = 0; load_cnt[i] = 0; err_cnt[i] = 0;
         mon_cnt[i] = 0; mon_acc[i] = '0;
         mst_tx[i] = '0; slv_tx[i] = '0;
      end

      // Reset state
      wait_clk(5);
      check("rst_pulses_miso", {17'd0, miso, rdy, tx_load}, 32'd0);
      check("rst_err_active", {22'd0, err, active}, 32'd0);
      check("rst_dout", {dout16, dout8[0], dout8[3]}, 32'd0);
      for (int i = 0; i < 5; i++) check("rst_wcnt", {16'd0, wcnt[i]}, 32'd0);
      rst_n = 1'b1;
      wait_clk(8);

      // Mode 0: 0xA5 in, 0x3C out
      mst_tx[0] = 16'h00A5; slv_tx[0] = 16'h003C; slv_tx[1] = 16'h0000;
      r0 = rdy_cnt[0]; l0 = load_cnt[0];
      frame(0, 1, 0);
      check("m0_dout", {24'd0, dout8[0]}, 32'hA5);
      check("m0_wcnt", {16'd0, wcnt[0]}, 32'd1);
      check("m0_rdy_pulses", rdy_cnt[0] - r0, 32'd1);
      check("m0_load_pulses", load_cnt[0] - l0, 32'd2);

      // 3-word frame: a load at frame start and one at each of the three completions
      mst_tx[0] = 16'h11; mst_tx[1] = 16'h22; mst_tx[2] = 16'h33;
      slv_tx[0] = 16'h44; slv_tx[1] = 16'h55; slv_tx[2] = 16'h66; slv_tx[3] = 16'h00;
      r0 = rdy_cnt[0]; l0 = load_cnt[0];
      frame(0, 3, 0);
      check("w3_wcnt", {16'd0, wcnt[0]}, 32'd3);
      check("w3_rdy_pulses", rdy_cnt[0] - r0, 32'd3);
      check("w3_load_pulses", load_cnt[0] - l0, 32'd4);

      // CS deasserted after 5 bits
      mst_tx[0] = 16'hFF; slv_tx[0] = 16'h00; slv_tx[1] = 16'h00;
      r0 = rdy_cnt[0]; e0 = err_cnt[0];
      frame(0, 0, 5);
      check("err_pulses", err_cnt[0] - e0, 32'd1);
      check("err_no_rdy", rdy_cnt[0] - r0, 32'd0);
      check("err_dout_kept", {24'd0, dout8[0]}, 32'h33);
      check("err_wcnt_cleared", {16'd0, wcnt[0]}, 32'd0);
      check("err_active_low", {31'd0, active[0]}, 32'd0);

      // Modes 1..3 back-to-back words
      for (int m = 1; m < 4; m++) begin
         mst_tx[0] = 16'h5A; mst_tx[1] = 16'hC3;
         slv_tx[0] = 16'h96; slv_tx[1] = 16'h3F; slv_tx[2] = 16'h00;
         r0 = rdy_cnt[m];
         frame(m, 2, 0);
         check("mode_rdy_pulses", rdy_cnt[m] - r0, 32'd2);
         check("mode_dout", {24'd0, dout8[m]}, 32'hC3);
         check("mode_wcnt", {16'd0, wcnt[m]}, 32'd2);
      end

      // 16-bit LSB first
      mst_tx[0] = 16'h1234; slv_tx[0] = 16'hBEEF; slv_tx[1] = 16'h0000;
      frame(4, 1, 0);
      check("w16_dout", {16'd0, dout16}, 32'h1234);

      // Reset after 3 bits, released with CS still low
      set_tx(0, 16'h3C);
      cs_n[0] = 1'b0;
      wait_clk(HP);
      for (int b = 0; b < 3; b++) do_bit(0, 1'b1);
      rst_n = 1'b0;
      wait_clk(3);
      check("rstmid_dout", {24'd0, dout8[0]}, 32'd0);
      check("rstmid_outs", {27'd0, miso[0], rdy[0], tx_load[0], err[0], active[0]}, 32'd0);
      check("rstmid_wcnt", {16'd0, wcnt[0]}, 32'd0);
      r0 = rdy_cnt[0];
      rst_n = 1'b1;
      wait_clk(4);
      exp_tx.push_back(16'h0000);   // MISO held low: slave is not in a frame
      mst_tx[0] = 16'h81;
      for (int b = 0; b < 8; b++) do_bit(0, mst_tx[0][7-b]);
      check("rstmid_no_word", rdy_cnt[0] - r0, 32'd0);
      check("rstmid_inactive", {31'd0, active[0]}, 32'd0);
      check("rstmid_dout_still0", {24'd0, dout8[0]}, 32'd0);
      wait_clk(HP);
      cs_n[0] = 1'b1;
      wait_clk(12);
      mst_tx[0] = 16'h81; slv_tx[0] = 16'h5E; slv_tx[1] = 16'h00;
      frame(0, 1, 0);
      check("rstmid_new_dout", {24'd0, dout8[0]}, 32'h81);
      check("rstmid_new_wcnt", {16'd0, wcnt[0]}, 32'd1);

      wait_clk(10);
      check("rx_queue_drained", exp_rx.size(), 32'd0);
      check("tx_queue_drained", exp_tx.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
